// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the multi-cycle data memory: FSM states, access
// size encoding and default wait-state latency.
package data_mem_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  localparam int WAIT_CYCLES_DEFAULT = 2;
  localparam int CNT_W               = 4;

  // Zero-extend a loaded byte to a full data word.
  function automatic logic [31:0] byte_zext(input logic [7:0] b);
    return {24'd0, b};
  endfunction

endpackage

// File: rtl/data_mem_unit_mem_byte_array.sv
// Byte-organised RAM: synchronous byte/word write, combinational read of the
// four bytes starting at the addressed base (big-endian order, MSB first).
module mem_byte_array
  import data_mem_unit_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  localparam int AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          size_b,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [AW-1:0] addr1_s;
  logic [AW-1:0] addr2_s;
  logic [AW-1:0] addr3_s;

  // Neighbouring byte addresses wrap inside the array so a byte access near
  // the top never indexes out of range; word accesses are always aligned.
  assign addr1_s = addr + AW'(1);
  assign addr2_s = addr + AW'(2);
  assign addr3_s = addr + AW'(3);

  assign rdata = {mem_q[addr], mem_q[addr1_s], mem_q[addr2_s], mem_q[addr3_s]};

  // Write port: one byte from wdata[7:0], or a full big-endian word.
  always_ff @(posedge clk) begin
    if (we) begin
      if (size_b == SIZE_BYTE) begin
        mem_q[addr] <= wdata[7:0];
      end else begin
        mem_q[addr]    <= wdata[31:24];
        mem_q[addr1_s] <= wdata[23:16];
        mem_q[addr2_s] <= wdata[15:8];
        mem_q[addr3_s] <= wdata[7:0];
      end
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory with request/ready handshake, configurable wait
// states, byte/word accesses and rejection of malformed requests.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        mRD,
  input  logic        mWR,
  input  logic        SizeB,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        ready,
  output logic        busy,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             size_q, size_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      dout_q, dout_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             mem_we_s;
  logic [31:0]      rdata_s;
  logic             req_bad_s;

  // A request is rejected for an ambiguous op, an address past the array or
  // a misaligned word access.
  assign req_bad_s = (mRD == mWR)
                   || (DAddr[31:AW] != {(32-AW){1'b0}})
                   || ((SizeB == SIZE_WORD) && (DAddr[1:0] != 2'd0));

  mem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we_s),
    .size_b(size_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata_s)
  );

  // Next-state and datapath control; the access uses only latched values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (req_bad_s) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            wr_d    = mWR;
            size_d  = SizeB;
            addr_d  = DAddr[AW-1:0];
            wdata_d = DataIn;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we_s = wr_q;
          if (wr_q) begin
            dout_d = dout_q;
          end else if (size_q == SIZE_BYTE) begin
            dout_d = byte_zext(rdata_s[31:24]);
          end else begin
            dout_d = rdata_s;
          end
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any pending access.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= SIZE_WORD;
      addr_q  <= {AW{1'b0}};
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign DataOut  = dout_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench: two instances (2 and 0 wait states) receive the same
// operations and are compared against a byte-array reference model.
module tb_data_mem_unit;

  localparam int DEPTH = 256;
  localparam int NCYC  = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req_i   [2];
  logic        mrd_i   [2];
  logic        mwr_i   [2];
  logic        sizeb_i [2];
  logic [31:0] daddr_i [2];
  logic [31:0] din_i   [2];
  logic [31:0] dout_o  [2];
  logic        ready_o [2];
  logic        busy_o  [2];
  logic        err_o   [2];

  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] ref_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .CLK(clk), .Reset(rst), .req(req_i[0]), .mRD(mrd_i[0]), .mWR(mwr_i[0]),
    .SizeB(sizeb_i[0]), .DAddr(daddr_i[0]), .DataIn(din_i[0]),
    .DataOut(dout_o[0]), .ready(ready_o[0]), .busy(busy_o[0]), .addr_err(err_o[0])
  );

  data_mem_unit #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(clk), .Reset(rst), .req(req_i[1]), .mRD(mrd_i[1]), .mWR(mwr_i[1]),
    .SizeB(sizeb_i[1]), .DAddr(daddr_i[1]), .DataIn(din_i[1]),
    .DataOut(dout_o[1]), .ready(ready_o[1]), .busy(busy_o[1]), .addr_err(err_o[1])
  );

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic rd, input logic wr,
                       input logic sz, input logic [31:0] a, input logic [31:0] dat);
    req_i[d]   = r;
    mrd_i[d]   = rd;
    mwr_i[d]   = wr;
    sizeb_i[d] = sz;
    daddr_i[d] = a;
    din_i[d]   = dat;
  endtask

  // One request to both instances; inputs are scrambled while each is busy.
  task automatic do_op(input string tag, input logic rd, input logic wr, input logic sz,
                       input logic [31:0] a, input logic [31:0] dat);
    logic        valid;
    logic [31:0] exp_dout;
    int rdy_at [2];
    int rdy_n  [2];
    int err_at [2];
    int err_n  [2];
    int w;
    valid = (rd != wr) && (a < DEPTH) && !((sz == 1'b0) && (a[1:0] != 2'd0));
    exp_dout = ref_dout;
    if (valid && rd) begin
      exp_dout = sz ? {24'd0, ref_mem[a[7:0]]} : word_at(a[7:0]);
    end
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b1, rd, wr, sz, a, dat);
      rdy_at[d] = -1; rdy_n[d] = 0; err_at[d] = -1; err_n[d] = 0;
    end
    @(posedge clk); #1;
    for (int n = 0; n < NCYC; n++) begin
      for (int d = 0; d < 2; d++) begin
        w = wc(d);
        check($sformatf("%s busy%0d n%0d", tag, d, n), 32'(busy_o[d]),
              32'(valid ? (n <= w + 1) : (n == 0)));
        check($sformatf("%s excl%0d n%0d", tag, d, n), 32'(ready_o[d] & err_o[d]), 32'd0);
        if (ready_o[d]) begin rdy_n[d]++; rdy_at[d] = n; end
        if (err_o[d])   begin err_n[d]++; err_at[d] = n; end
        if (n <= (valid ? w + 1 : 0)) begin
          drive(d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
        end else begin
          drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
      if (n < NCYC - 1) begin
        @(posedge clk); #1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      w = wc(d);
      check($sformatf("%s ready_cnt%0d", tag, d), 32'(rdy_n[d]), 32'(valid ? 1 : 0));
      check($sformatf("%s ready_at%0d", tag, d), 32'(rdy_at[d]), 32'(valid ? w + 1 : -1));
      check($sformatf("%s err_cnt%0d", tag, d), 32'(err_n[d]), 32'(valid ? 0 : 1));
      check($sformatf("%s err_at%0d", tag, d), 32'(err_at[d]), 32'(valid ? -1 : 0));
      check($sformatf("%s dout%0d", tag, d), dout_o[d], exp_dout);
    end
    if (valid && wr) begin
      if (sz) begin
        ref_mem[a[7:0]] = dat[7:0];
      end else begin
        ref_mem[a[7:0]]        = dat[31:24];
        ref_mem[a[7:0] + 8'd1] = dat[23:16];
        ref_mem[a[7:0] + 8'd2] = dat[15:8];
        ref_mem[a[7:0] + 8'd3] = dat[7:0];
      end
    end
    ref_dout = exp_dout;
  endtask

  task automatic reset_mid_write();
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst busy_before%0d", d), 32'(busy_o[d]), 32'd1);
      check($sformatf("rst ready_before%0d", d), 32'(ready_o[d]), 32'd0);
      drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst dout%0d", d), dout_o[d], 32'd0);
      check($sformatf("rst busy%0d", d), 32'(busy_o[d]), 32'd0);
      check($sformatf("rst ready%0d", d), 32'(ready_o[d]), 32'd0);
      check($sformatf("rst err%0d", d), 32'(err_o[d]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    ref_dout = 32'd0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
        check($sformatf("rst ready_after%0d n%0d", d, n), 32'(ready_o[d]), 32'd0);
    end
  endtask

  // req held high: every accepted read completes on a fixed period.
  task automatic hold_req();
    logic [31:0] exp;
    int last [2];
    int cnt  [2];
    int w;
    exp = word_at(8'h10);
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
      last[d] = -1; cnt[d] = 0;
    end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        w = wc(d);
        if (ready_o[d]) begin
          if (last[d] < 0) check($sformatf("hold first%0d", d), 32'(n), 32'(w + 1));
          else             check($sformatf("hold gap%0d", d), 32'(n - last[d]), 32'(w + 3));
          check($sformatf("hold dout%0d", d), dout_o[d], exp);
          last[d] = n;
          cnt[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      w = wc(d);
      check($sformatf("hold count%0d", d), 32'(cnt[d]), 32'((39 - (w + 1)) / (w + 3) + 1));
      drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    repeat (8) @(posedge clk);
    #1;
    ref_dout = exp;
  endtask

  initial begin
    logic [31:0] a;
    logic        rd, wr, sz;
    int          r;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dout%0d", d), dout_o[d], 32'd0);
      check($sformatf("reset ready%0d", d), 32'(ready_o[d]), 32'd0);
      check($sformatf("reset busy%0d", d), 32'(busy_o[d]), 32'd0);
      check($sformatf("reset err%0d", d), 32'(err_o[d]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    ref_dout = 32'd0;
    @(posedge clk); #1;

    // Fill the whole array so every later read has a known expectation.
    for (int i = 0; i < DEPTH / 4; i++) do_op("init", 1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom);

    do_op("wr_word", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    do_op("rd_word", 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    do_op("wr_byte", 1'b0, 1'b1, 1'b1, 32'h12, 32'h000000AA);
    do_op("rd_word2", 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    do_op("rd_byte", 1'b1, 1'b0, 1'b1, 32'h13, 32'd0);
    do_op("err_align", 1'b1, 1'b0, 1'b0, 32'h11, 32'd0);
    do_op("err_range", 1'b0, 1'b1, 1'b0, 32'h100, 32'h11223344);
    do_op("rd_zero", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
    do_op("err_both", 1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    do_op("err_none", 1'b0, 1'b0, 1'b0, 32'h10, 32'd0);
    do_op("rd_top_byte", 1'b1, 1'b0, 1'b1, 32'hFF, 32'd0);
    reset_mid_write();
    do_op("rd_after_rst", 1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
    hold_req();

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : (r < 6);
      wr = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : (r >= 6);
      sz = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = 32'h100 + 32'($urandom_range(0, 255));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 255));
      endcase
      if (!sz && ($urandom_range(0, 3) != 0)) a[1:0] = 2'd0;
      do_op($sformatf("rand%0d", i), rd, wr, sz, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
